// File: rtl/upd1771c_fetch.sv
// uPD1771C instruction-fetch front end: phase generator, PC, return stack, synchronous-ROM IR latch.
// Optional interrupt vector path is enabled by defining UPD1771C_FETCH_INT_EN.
module upd1771c_fetch #(
  parameter int              AW          = 12,
  parameter int              ROM_AW      = 9,
  parameter int              DIV         = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [AW-1:0]   INT_VEC     = AW'(12'h020)
) (
  input  logic                           CLK,
  input  logic                           RES,
  input  logic                           JMP,
  input  logic [AW-1:0]                  JMP_ADDR,
  input  logic                           CALL,
  input  logic                           RET,
  input  logic                           SKIP,
  input  logic                           INT_REQ,
  output logic [ROM_AW-1:0]              ROM_ADDR,
  input  logic [15:0]                    ROM_DATA,
  output logic                           CP1,
  output logic                           CP2,
  output logic [AW-1:0]                  PC,
  output logic [15:0]                    IR,
  output logic                           IR_VALID,
  output logic [$clog2(STACK_DEPTH):0]   SP,
  output logic                           STACK_OVF,
  output logic                           STACK_UNF,
  output logic                           INT_ACK
);

  localparam int PHW = $clog2(DIV);
  localparam int PW  = $clog2(STACK_DEPTH);
  localparam int SPW = PW + 1;

  localparam logic [PHW-1:0] PH_LOAD = PHW'(1);
  localparam logic [PHW-1:0] PH_CP2  = PHW'(DIV / 2);
  localparam logic [PHW-1:0] PH_LAST = PHW'(DIV - 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  typedef enum logic [5:0] {
    SEL_INC  = 6'b000001,
    SEL_SKIP = 6'b000010,
    SEL_JMP  = 6'b000100,
    SEL_CALL = 6'b001000,
    SEL_RET  = 6'b010000,
    SEL_INT  = 6'b100000
  } sel_e;

  logic [PHW-1:0] r_ph;
  logic [AW-1:0]  r_pc;
  logic [AW-1:0]  r_target;
  logic [15:0]    r_ir;
  logic           r_ir_valid;
  sel_e           r_sel;
  logic [AW-1:0]  r_stack [STACK_DEPTH];
  logic [PW-1:0]  r_wp;
  logic [SPW-1:0] r_sp;
  logic           r_ovf;
  logic           r_unf;
  logic           r_int_ack;

  logic           w_int_req;
  logic           w_apply;
  logic           w_push;
  logic           w_full;
  logic           w_empty;
  logic           w_rom_hi;
  logic [PW-1:0]  w_wp_dec;
  logic [AW-1:0]  w_pc_inc;
  logic [AW-1:0]  w_pc_skip;

`ifdef UPD1771C_FETCH_INT_EN
  assign w_int_req = INT_REQ;
`else
  logic w_unused_int;
  assign w_int_req    = 1'b0;
  assign w_unused_int = &{1'b0, INT_REQ, INT_VEC};
`endif

  assign w_apply   = (r_ph == PH_LAST);
  assign w_push    = w_apply && ((r_sel == SEL_CALL) || (r_sel == SEL_INT));
  assign w_full    = (r_sp == SP_FULL);
  assign w_empty   = (r_sp == '0);
  assign w_rom_hi  = |r_pc[AW-1:ROM_AW];
  assign w_wp_dec  = r_wp - PW'(1);
  assign w_pc_inc  = r_pc + AW'(1);
  assign w_pc_skip = r_pc + AW'(2);

  // NOTE: sequential state is always assigned with <= so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_ph       <= '0;
      r_pc       <= '0;
      r_target   <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_sel      <= SEL_INC;
      r_wp       <= '0;
      r_sp       <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_int_ack  <= 1'b0;
    end else begin
      r_ph      <= w_apply ? '0 : r_ph + PHW'(1);
      r_int_ack <= 1'b0;

      // Out-of-ROM addresses fetch a NOP regardless of what the ROM returns.
      if (r_ph == PH_LOAD) begin
        r_ir       <= w_rom_hi ? 16'h0000 : ROM_DATA;
        r_ir_valid <= 1'b1;
      end

      if (r_ph == PH_CP2) begin
        r_target <= JMP_ADDR;
        if (w_int_req)  r_sel <= SEL_INT;
        else if (RET)   r_sel <= SEL_RET;
        else if (CALL)  r_sel <= SEL_CALL;
        else if (JMP)   r_sel <= SEL_JMP;
        else if (SKIP)  r_sel <= SEL_SKIP;
        else            r_sel <= SEL_INC;
      end

      if (w_apply) begin
        unique case (r_sel)
          SEL_SKIP: r_pc <= w_pc_skip;
          SEL_JMP:  r_pc <= r_target;
          SEL_CALL: r_pc <= r_target;
          SEL_RET:  r_pc <= w_empty ? '0 : r_stack[w_wp_dec];
`ifdef UPD1771C_FETCH_INT_EN
          SEL_INT: begin
            r_pc      <= INT_VEC;
            r_int_ack <= 1'b1;
          end
`endif
          default:  r_pc <= w_pc_inc;
        endcase

        // A full stack keeps wrapping wp so the oldest entry is the one overwritten.
        if (w_push) begin
          r_wp <= r_wp + PW'(1);
          if (w_full) r_ovf <= 1'b1;
          else        r_sp  <= r_sp + SPW'(1);
        end

        if (r_sel == SEL_RET) begin
          if (w_empty) begin
            r_unf <= 1'b1;
          end else begin
            r_wp <= w_wp_dec;
            r_sp <= r_sp - SPW'(1);
          end
        end
      end
    end
  end

  // NOTE: the stack array is plain storage and is not reset; SP and wp define which entries are live.
  always_ff @(posedge CLK) begin
    if (!RES && w_push) r_stack[r_wp] <= w_pc_inc;
  end

  assign ROM_ADDR  = r_pc[ROM_AW-1:0];
  assign CP1       = (r_ph == '0);
  assign CP2       = (r_ph == PH_CP2);
  assign PC        = r_pc;
  assign IR        = r_ir;
  assign IR_VALID  = r_ir_valid;
  assign SP        = r_sp;
  assign STACK_OVF = r_ovf;
  assign STACK_UNF = r_unf;
  assign INT_ACK   = r_int_ack;

endmodule

// File: tb/tb_upd1771c_fetch.sv
// Self-checking bench for upd1771c_fetch: reference PC/stack model plus an IR scoreboard.
`timescale 1ns/1ps
module tb_upd1771c_fetch;

  localparam int AW = 12;
  localparam int ROM_AW = 9;
  localparam int DIV = 8;
  localparam int SD = 4;
  localparam logic [11:0] VEC = 12'h020;
`ifdef UPD1771C_FETCH_INT_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RES = 1'b1;
  logic        JMP = 1'b0, CALL = 1'b0, RET = 1'b0, SKIP = 1'b0, INT_REQ = 1'b0;
  logic [11:0] JMP_ADDR = '0;
  logic [8:0]  ROM_ADDR;
  logic [15:0] ROM_DATA = '0;
  logic        CP1, CP2, IR_VALID, STACK_OVF, STACK_UNF, INT_ACK;
  logic [11:0] PC;
  logic [15:0] IR;
  logic [2:0]  SP;

  upd1771c_fetch #(.AW(AW), .ROM_AW(ROM_AW), .DIV(DIV), .STACK_DEPTH(SD), .INT_VEC(VEC)) dut (
    .CLK(CLK), .RES(RES), .JMP(JMP), .JMP_ADDR(JMP_ADDR), .CALL(CALL), .RET(RET),
    .SKIP(SKIP), .INT_REQ(INT_REQ), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA),
    .CP1(CP1), .CP2(CP2), .PC(PC), .IR(IR), .IR_VALID(IR_VALID), .SP(SP),
    .STACK_OVF(STACK_OVF), .STACK_UNF(STACK_UNF), .INT_ACK(INT_ACK)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM: data one clock after the address.
  logic [15:0] rom [512];
  logic        rom_override = 1'b0;
  always @(posedge CLK) ROM_DATA <= rom_override ? 16'hBEEF : rom[ROM_ADDR];

  // Bench-side machine-cycle phase, derived from reset release only.
  int tb_ph = 0;
  always @(posedge CLK) tb_ph <= RES ? 0 : ((tb_ph == DIV - 1) ? 0 : tb_ph + 1);

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_ir_q [$];
  logic        fresh = 1'b0;

  logic [11:0] m_pc;
  logic [11:0] m_stack [$];
  logic        m_ovf, m_unf, m_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [11:0] a);
    if (a[11:9] != 3'd0) return 16'h0000;
    return rom_override ? 16'hBEEF : rom[a[8:0]];
  endfunction

  task automatic m_reset();
    m_pc = '0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_ack = 1'b0;
    exp_ir_q.delete();
  endtask

  task automatic m_push(input logic [11:0] v);
    if (m_stack.size() == SD) begin
      void'(m_stack.pop_front());
      m_ovf = 1'b1;
    end
    m_stack.push_back(v);
  endtask

  task automatic check_state();
    check("pc", PC, m_pc);
    check("rom_addr", ROM_ADDR, m_pc[8:0]);
    check("sp", SP, m_stack.size());
    check("stack_ovf", STACK_OVF, m_ovf);
    check("stack_unf", STACK_UNF, m_unf);
    check("int_ack", INT_ACK, m_ack);
  endtask

  task automatic start_cycle();
    check_state();
    exp_ir_q.push_back(exp_word(m_pc));
  endtask

  task automatic reset_checks();
    check("rst_pc", PC, 0);
    check("rst_ir", IR, 0);
    check("rst_ir_valid", IR_VALID, 0);
    check("rst_sp", SP, 0);
    check("rst_ovf", STACK_OVF, 0);
    check("rst_unf", STACK_UNF, 0);
    check("rst_int_ack", INT_ACK, 0);
    check("rst_cp1", CP1, 1);
    check("rst_cp2", CP2, 0);
    check("rst_rom_addr", ROM_ADDR, 0);
  endtask

  // One machine cycle: entered and left on the negedge where tb_ph == 0.
  task automatic mcycle(input logic j, input logic c, input logic r, input logic s,
                        input logic i, input logic [11:0] a);
    start_cycle();
    JMP = j; CALL = c; RET = r; SKIP = s; INT_REQ = i; JMP_ADDR = a;
    repeat (DIV / 2 + 1) @(negedge CLK);
    // Controls change after the sampling edge; the DUT must ignore this.
    JMP = 1'b0; CALL = 1'b0; RET = 1'b0; SKIP = 1'b0; INT_REQ = 1'b0; JMP_ADDR = 12'hFFF;
    repeat (DIV / 2 - 1) @(negedge CLK);
    m_ack = 1'b0;
    if (i && INT_ON) begin
      m_push(m_pc + 12'd1); m_pc = VEC; m_ack = 1'b1;
    end else if (r) begin
      if (m_stack.size() == 0) begin m_pc = '0; m_unf = 1'b1; end
      else m_pc = m_stack.pop_back();
    end else if (c) begin
      m_push(m_pc + 12'd1); m_pc = a;
    end else if (j) m_pc = a;
    else if (s)     m_pc = m_pc + 12'd2;
    else            m_pc = m_pc + 12'd1;
  endtask

  task automatic inc();  mcycle(0, 0, 0, 0, 0, '0); endtask
  task automatic jmp(input logic [11:0] a); mcycle(1, 0, 0, 0, 0, a); endtask
  task automatic call(input logic [11:0] a); mcycle(0, 1, 0, 0, 0, a); endtask
  task automatic ret(); mcycle(0, 0, 1, 0, 0, '0); endtask

  always @(negedge CLK) begin
    if (!RES) begin
      check("cp1", CP1, tb_ph == 0);
      check("cp2", CP2, tb_ph == DIV / 2);
      if (tb_ph == 1) begin
        check("int_ack_low", INT_ACK, 0);
        if (fresh) begin
          check("ir_valid_pre", IR_VALID, 0);
          check("ir_pre", IR, 0);
          fresh = 1'b0;
        end
      end
      if (tb_ph == 2) begin
        check("ir_sb_depth", exp_ir_q.size(), 1);
        if (exp_ir_q.size() != 0) check("ir", IR, exp_ir_q.pop_front());
        check("ir_valid", IR_VALID, 1);
      end
    end
  end

  initial begin
    logic [11:0] ret_exp [5];
    for (int k = 0; k < 512; k++) rom[k] = 16'hA000 | 16'(k);
    rom[0] = 16'h1111; rom[1] = 16'h2222; rom[2] = 16'h3333; rom[3] = 16'h4444;
    ret_exp[0] = 12'h051; ret_exp[1] = 12'h041; ret_exp[2] = 12'h031;
    ret_exp[3] = 12'h021; ret_exp[4] = 12'h000;

    m_reset();
    RES = 1'b1;
    repeat (3) @(negedge CLK);
    reset_checks();
    RES = 1'b0; fresh = 1'b1;

    // Sequential fetch 0..4 (IR 1111, 2222, 3333, 4444, ...), then CALL/RET round trip.
    repeat (5) inc();
    call(12'h100);
    check("call_target", PC, 12'h100);
    check("call_sp", SP, 1);
    repeat (3) inc();
    check("pre_ret_pc", PC, 12'h103);
    ret();
    check("ret_pc", PC, 12'h006);
    check("ret_sp", SP, 0);
    check("ret_flags", {STACK_OVF, STACK_UNF}, 2'b00);

    // Five nested calls overflow a 4-deep stack; five returns underflow it.
    jmp(12'h010);
    for (int k = 1; k <= 5; k++) call(12'((k + 1) * 16));
    check("nest_ovf", STACK_OVF, 1);
    check("nest_sp", SP, 4);
    for (int k = 0; k < 5; k++) begin
      ret();
      check("nest_ret_pc", PC, ret_exp[k]);
    end
    check("nest_unf", STACK_UNF, 1);

    // Wrap-around skip and a fetch above the ROM window.
    jmp(12'hFFF);
    mcycle(0, 0, 0, 1, 0, '0);
    check("skip_wrap", PC, 12'h001);
    jmp(12'h200);
    rom_override = 1'b1;
    inc();
    rom_override = 1'b0;

    // Simultaneous JMP+SKIP+CALL: CALL wins, stack top is 9.
    jmp(12'h008);
    mcycle(1, 1, 0, 1, 0, 12'h0AB);
    check("prio_pc", PC, 12'h0AB);
    ret();
    check("prio_top", PC, 12'h009);
    jmp(12'h008);
    mcycle(1, 1, 0, 1, 0, 12'h0AB);
    check("prio_pc2", PC, 12'h0AB);

    // Reset asserted at ph 3 of the following cycle.
    start_cycle();
    repeat (3) @(negedge CLK);
    RES = 1'b1;
    @(negedge CLK);
    reset_checks();
    m_reset();
    @(negedge CLK);
    RES = 1'b0; fresh = 1'b1;

    // Interrupt versus CALL at PC 0x40.
    jmp(12'h040);
    mcycle(0, 1, 0, 0, 1, 12'h077);
    check("int_pc", PC, INT_ON ? 12'h020 : 12'h077);
    check("int_ack_pulse", INT_ACK, INT_ON);
    check("int_sp", SP, 1);
    inc();
    ret();
    check("int_ret_pc", PC, 12'h041);
    inc();
    check_state();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
